// File: rtl/bram_pulse_reader.sv
// Read-side initiator for the pulse-model sample BRAM: fetches a contiguous
// sample table (optionally repeated) and streams it over valid/ready.
module bram_pulse_reader #(
    parameter int unsigned ADDR_STEP  = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clka,
    input  logic        rsta_n,
    input  logic        start,
    input  logic [31:0] cfg_start_addr,
    input  logic [15:0] cfg_num_samples,
    input  logic [7:0]  cfg_repeat,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        bram_en,
    output logic        bram_we,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    input  logic [31:0] bram_rdata,
    output logic        m_valid,
    output logic [31:0] m_data,
    output logic        m_last,
    input  logic        m_ready
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;

    // latched command
    logic [31:0] cfg_addr;
    logic [15:0] cfg_num;
    logic [7:0]  cfg_passes;

    // read-issue position
    logic [15:0] rd_idx;
    logic [7:0]  rd_pass;
    logic        rd_done;

    // read issued last cycle; its data is on bram_rdata now
    logic        inflight;
    logic        inflight_last;

    // two-entry skid buffer: head feeds the output, tail absorbs one stall
    logic        h_valid;
    logic        h_last;
    logic [31:0] h_data;
    logic        t_valid;
    logic        t_last;
    logic [31:0] t_data;

    logic        pop_c;
    logic [1:0]  occ_c;
    logic        issue_c;
    logic        last_idx_c;
    logic        final_rd_c;
    logic        final_hs_c;
    logic        abort_c;

    // The arriving read word counts as the buffer head when the buffer is empty,
    // so the first sample is visible in the same cycle its data returns.
    assign m_valid = h_valid | inflight;
    assign m_data  = h_valid ? h_data : (inflight ? bram_rdata : h_data);
    assign m_last  = h_valid ? h_last : (inflight & inflight_last);

    assign bram_we    = 1'b0;
    assign bram_wdata = 32'd0;

    // Handshake, occupancy and read-issue decision for this cycle
    always_comb begin
        pop_c      = m_valid & m_ready;
        occ_c      = {1'b0, h_valid} + {1'b0, t_valid} + {1'b0, inflight};
        last_idx_c = (rd_idx == cfg_num - 16'd1);
        final_rd_c = last_idx_c && (rd_pass == cfg_passes - 8'd1);
        final_hs_c = pop_c & m_last;
        abort_c    = (state == S_RUN) && abort;
        issue_c    = (state == S_RUN) && !abort && !rd_done &&
                     (32'(occ_c) + 32'd1 <= FIFO_DEPTH + 32'(pop_c));
        bram_en    = issue_c;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (cfg_num_samples == 16'd0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (final_hs_c) begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register with registered status outputs
    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
            done  <= (state_nxt == S_FINISH);
        end
    end

    // Command latch and read address / index sequencing
    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            cfg_addr   <= 32'd0;
            cfg_num    <= 16'd0;
            cfg_passes <= 8'd0;
            rd_idx     <= 16'd0;
            rd_pass    <= 8'd0;
            rd_done    <= 1'b0;
            bram_addr  <= 32'd0;
        end else if ((state == S_IDLE) && start) begin
            cfg_addr   <= cfg_start_addr;
            cfg_num    <= cfg_num_samples;
            cfg_passes <= (cfg_repeat == 8'd0) ? 8'd1 : cfg_repeat;
            rd_idx     <= 16'd0;
            rd_pass    <= 8'd0;
            rd_done    <= (cfg_num_samples == 16'd0);
            bram_addr  <= cfg_start_addr;
        end else if (issue_c) begin
            if (last_idx_c) begin
                rd_idx    <= 16'd0;
                rd_pass   <= rd_pass + 8'd1;
                rd_done   <= final_rd_c;
                bram_addr <= cfg_addr;
            end else begin
                rd_idx    <= rd_idx + 16'd1;
                bram_addr <= bram_addr + 32'(ADDR_STEP);
            end
        end
    end

    // In-flight read tracking; abort drops a pending read
    always_ff @(posedge clka) begin
        if (!rsta_n || abort_c) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue_c;
            inflight_last <= issue_c & final_rd_c;
        end
    end

    // Skid buffer push/pop; abort flushes it
    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            h_valid <= 1'b0;
            h_last  <= 1'b0;
            h_data  <= 32'd0;
            t_valid <= 1'b0;
            t_last  <= 1'b0;
            t_data  <= 32'd0;
        end else if (abort_c) begin
            h_valid <= 1'b0;
            h_last  <= 1'b0;
            t_valid <= 1'b0;
            t_last  <= 1'b0;
        end else if (pop_c) begin
            if (h_valid && t_valid) begin
                h_data  <= t_data;
                h_last  <= t_last;
                t_valid <= inflight;
                t_last  <= inflight & inflight_last;
                if (inflight) begin
                    t_data <= bram_rdata;
                end
            end else if (h_valid) begin
                h_valid <= inflight;
                h_last  <= inflight & inflight_last;
                if (inflight) begin
                    h_data <= bram_rdata;
                end
            end else begin
                h_valid <= 1'b0;
                h_last  <= 1'b0;
            end
        end else if (inflight) begin
            if (!h_valid) begin
                h_valid <= 1'b1;
                h_last  <= inflight_last;
                h_data  <= bram_rdata;
            end else begin
                t_valid <= 1'b1;
                t_last  <= inflight_last;
                t_data  <= bram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_bram_pulse_reader.sv
// Testbench for bram_pulse_reader: BRAM model, sample/address scoreboard
// built from the table rules, directed scenarios plus randomized runs.
module tb_bram_pulse_reader;

    localparam int unsigned ADDR_STEP = 4;

    logic        clka = 1'b0;
    logic        rsta_n;
    logic        start;
    logic [31:0] cfg_start_addr;
    logic [15:0] cfg_num_samples;
    logic [7:0]  cfg_repeat;
    logic        abort;
    logic        busy;
    logic        done;
    logic        bram_en;
    logic        bram_we;
    logic [31:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata = 32'd0;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;

    always #5 clka = ~clka;

    bram_pulse_reader #(.ADDR_STEP(ADDR_STEP), .FIFO_DEPTH(2)) dut (
        .clka(clka), .rsta_n(rsta_n), .start(start),
        .cfg_start_addr(cfg_start_addr), .cfg_num_samples(cfg_num_samples),
        .cfg_repeat(cfg_repeat), .abort(abort), .busy(busy), .done(done),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .m_valid(m_valid),
        .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // BRAM contents: value = address ^ key (key 0 gives value = address)
    logic [31:0] key = 32'd0;
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a ^ key;
    endfunction

    // One-cycle registered read port
    always @(posedge clka) begin
        if (bram_en) bram_rdata <= mem_val(bram_addr);
    end

    // scoreboard state
    logic [32:0] exp_q[$];
    logic [31:0] addr_q[$];
    int cyc_n = 0;
    int issued, accepted, first_valid_cyc, last_hs_cyc, done_cyc, done_cnt, last_cnt;
    logic prev_stall;
    logic [31:0] prev_data;
    logic prev_last;
    logic rst_v = 1'b0;
    logic [5:0] bp_pat = 6'b101001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic clear_sb();
        issued = 0; accepted = 0; first_valid_cyc = -1; last_hs_cyc = -1;
        done_cyc = -1; done_cnt = 0; last_cnt = 0; prev_stall = 1'b0;
    endtask

    // Expected read addresses and output samples for one command
    task automatic build(input logic [31:0] sa, input logic [15:0] n, input logic [7:0] rep);
        int passes;
        logic [31:0] a;
        passes = (rep == 8'd0) ? 1 : int'(rep);
        exp_q.delete();
        addr_q.delete();
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < int'(n); k++) begin
                a = sa + 32'(k * ADDR_STEP);
                addr_q.push_back(a);
                exp_q.push_back({(p == passes - 1) && (k == int'(n) - 1), mem_val(a)});
            end
        end
    endtask

    // Drive inputs at negedge, then observe and score this cycle
    task automatic tick(input logic rdy, input logic st, input logic ab);
        logic pop;
        logic [31:0] ea;
        logic [32:0] ed;
        @(negedge clka);
        rsta_n = rst_v; m_ready = rdy; start = st; abort = ab;
        #1;
        cyc_n++;
        pop = m_valid & m_ready;
        if (prev_stall) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data", m_data, prev_data);
            check("stall_last", 32'(m_last), 32'(prev_last));
        end
        if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc_n;
        if (bram_en) begin
            ea = (addr_q.size() != 0) ? addr_q.pop_front() : ~bram_addr;
            check("read_addr", bram_addr, ea);
            check("outstanding_le_2", 32'(int'((issued - accepted + 1 - int'(pop)) <= 2)), 32'd1);
            issued++;
        end
        if (pop) begin
            ed = (exp_q.size() != 0) ? exp_q.pop_front() : {~m_last, ~m_data};
            check("m_data", m_data, ed[31:0]);
            check("m_last", 32'(m_last), 32'(ed[32]));
            accepted++;
            if (m_last) begin
                last_cnt++;
                last_hs_cyc = cyc_n;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        prev_stall = m_valid & ~m_ready & ~ab & rst_v;
        prev_data  = m_data;
        prev_last  = m_last;
    endtask

    // One complete command; mode 0: ready=1, 1: fixed stall pattern, 2: random
    task automatic run_test(input logic [31:0] sa, input logic [15:0] n, input logic [7:0] rep,
                            input int mode, input logic fin_start);
        int total, cs, budget, k;
        logic rdy, st;
        total = int'(n) * ((rep == 8'd0) ? 1 : int'(rep));
        clear_sb();
        build(sa, n, rep);
        cfg_start_addr = sa; cfg_num_samples = n; cfg_repeat = rep;
        tick(1'b1, 1'b1, 1'b0);
        cs = cyc_n;
        budget = total * 8 + 20;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = bp_pat[k % 6];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            st = fin_start && (total > 0) && (last_hs_cyc == cyc_n);
            tick(rdy, st, 1'b0);
            if (k == 0) begin
                check("busy_after_start", 32'(busy), 32'd1);
                cfg_start_addr  = $urandom;
                cfg_num_samples = 16'($urandom_range(1, 50));
                cfg_repeat      = 8'($urandom_range(1, 4));
            end
            k++;
        end
        tick(1'b1, 1'b0, 1'b0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_single", 32'(done_cnt), 32'd1);
        check("samples_out", 32'(accepted), 32'(total));
        check("reads_issued", 32'(issued), 32'(total));
        check("samples_left", 32'(exp_q.size()), 32'd0);
        check("last_count", 32'(last_cnt), (total > 0) ? 32'd1 : 32'd0);
        if (total > 0) begin
            check("done_after_last", 32'(done_cyc), 32'(last_hs_cyc + 1));
        end else begin
            check("done_zero_len", 32'(done_cyc), 32'(cs + 1));
        end
        if (mode == 0 && total > 0) begin
            check("first_valid_lat", 32'(first_valid_cyc), 32'(cs + 2));
            check("last_hs_cyc", 32'(last_hs_cyc), 32'(cs + 1 + total));
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_bram_en"}, 32'(bram_en), 32'd0);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_last"}, 32'(m_last), 32'd0);
        check({tag, "_bram_addr"}, bram_addr, 32'd0);
        check({tag, "_m_data"}, m_data, 32'd0);
    endtask

    initial begin
        logic [31:0] sa;
        int k;
        rsta_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
        cfg_start_addr = 32'd0; cfg_num_samples = 16'd0; cfg_repeat = 8'd0;
        clear_sb();

        // reset state
        rst_v = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        rst_v = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        check_idle_zero("reset");
        check("reset_we", 32'(bram_we), 32'd0);
        check("reset_wdata", bram_wdata, 32'd0);

        // basic pass, value = address
        key = 32'd0;
        run_test(32'd0, 16'd8, 8'd1, 0, 1'b0);
        // backpressure pattern
        run_test(32'd0, 16'd8, 8'd1, 1, 1'b0);
        // repeat with start pulsed during the finish cycle
        key = $urandom;
        run_test(32'd16, 16'd3, 8'd3, 0, 1'b1);
        // zero length
        run_test(32'd64, 16'd0, 8'd5, 0, 1'b0);
        // repeat=0 behaves as one pass
        run_test(32'd40, 16'd5, 8'd0, 2, 1'b0);
        // randomized commands, first one wraps the 32-bit address
        for (int r = 0; r < 6; r++) begin
            key = $urandom;
            sa = (r == 0) ? 32'hFFFF_FFF4 : $urandom;
            run_test(sa, 16'($urandom_range(1, 12)), 8'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        // abort mid-stream after three transfers
        key = $urandom;
        clear_sb();
        build(32'h100, 16'd100, 8'd1);
        cfg_start_addr = 32'h100; cfg_num_samples = 16'd100; cfg_repeat = 8'd1;
        tick(1'b1, 1'b1, 1'b0);
        k = 0;
        while (accepted < 3 && k < 20) begin
            tick(1'b1, 1'b0, 1'b0);
            k++;
        end
        check("abort_pre_count", 32'(accepted), 32'd3);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_m_valid", 32'(m_valid), 32'd0);
        check("abort_bram_en", 32'(bram_en), 32'd0);
        tick(1'b1, 1'b0, 1'b0);
        check("abort_idle_valid", 32'(m_valid), 32'd0);
        check("abort_idle_en", 32'(bram_en), 32'd0);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_test(32'h100, 16'd4, 8'd1, 0, 1'b0);

        // ignored start while busy, then reset mid-stream
        key = $urandom;
        clear_sb();
        build(32'h2000, 16'd10, 8'd2);
        cfg_start_addr = 32'h2000; cfg_num_samples = 16'd10; cfg_repeat = 8'd2;
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
        cfg_start_addr = 32'h9000; cfg_num_samples = 16'd3; cfg_repeat = 8'd1;
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("ignored_start_busy", 32'(busy), 32'd1);
        check("ignored_start_progress", 32'(accepted), 32'd4);
        rst_v = 1'b0;
        tick(1'b1, 1'b0, 1'b0);
        rst_v = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        check_idle_zero("midreset");
        check("midreset_no_done", 32'(done_cnt), 32'd0);
        key = $urandom;
        run_test(32'h3000, 16'd6, 8'd2, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
